video_pattern_gen: RTL and testbench
====================================

// Module: video_pattern_gen
// PURPOSE
//  Source end of the ISP pixel-stream interface. Generates hsync/vsync/de
//  timing plus an 8-bit test-pattern pixel stream, driving the filter chain
//  (gauss, sobel, ...) for bring-up and regression without a camera.
//  One pixel per clk. Line order: active, front porch, sync, back porch.
// PARAMETERS
//  H_ACTIVE  640  active pixels per line
//  H_FP      16   horizontal front porch (clk)
//  H_SYNC    96   hsync width (clk)
//  H_BP      48   horizontal back porch (clk)
//  V_ACTIVE  480  active lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync width (lines)
//  V_BP      33   vertical back porch (lines)
//  HS_POL    0    hsync active level
//  VS_POL    0    vsync active level
//  CHK_SHIFT 3    checkerboard square = 2**CHK_SHIFT pixels
//  CNT_W     12   h/v counter width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  clk            in   1  pixel clock
//  rst            in   1  synchronous reset, active-high
//  en             in   1  run request (level)
//  pat_sel        in   2  0 h-ramp, 1 v-ramp, 2 checkerboard, 3 constant
//  pat_const      in   8  pixel value for pat_sel=3
//  hsync_o        out  1  line sync, level per HS_POL
//  vsync_o        out  1  frame sync, level per VS_POL
//  de_o           out  1  active-pixel strobe
//  data_o         out  8  pixel value; 0 when de_o=0
//  frame_start_o  out  1  1-clk pulse with pixel (0,0)
//  busy_o         out  1  1 while a frame is in progress
// BEHAVIOUR
//  - Reset: state IDLE, h_cnt=v_cnt=0, de_o=0, data_o=0, frame_start_o=0,
//    busy_o=0, hsync_o=~HS_POL, vsync_o=~VS_POL.
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//  - FSM: IDLE -> RUN when en=1 (counters cleared to 0 in that cycle).
//    RUN: h_cnt increments each clk, wraps at H_TOTAL-1 and increments v_cnt;
//    v_cnt wraps at V_TOTAL-1. At last pixel (H_TOTAL-1,V_TOTAL-1): if en=1
//    wrap and continue, else -> IDLE. Dropping en never truncates a frame.
//  - All outputs registered from the counters: 1 clk counter->output latency.
//    en high in IDLE at cycle N -> de_o=1 and frame_start_o=1 at cycle N+2.
//  - de_o=1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
//  - hsync active iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
//  - vsync active iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC;
//    edges occur at h_cnt==0.
//  - busy_o=1 in RUN, aligned with outputs (goes 0 one clk after last pixel).
//  - pat_sel and pat_const latched only at (0,0); changes mid-frame ignored.
//  - Pattern (x=h_cnt, y=v_cnt in active area): h-ramp x[7:0]; v-ramp y[7:0];
//    checkerboard {8{x[CHK_SHIFT]^y[CHK_SHIFT]}}; constant pat_const.
//    8-bit results truncate (wrap) beyond 255.
//  - rst mid-frame: outputs to reset values next clk, frame abandoned.
// CONFIGURATION
//  VGEN_MOVING_EN defined: 8-bit frame_idx increments at each frame wrap
//  (reset 0, held in IDLE); h-ramp = (x+frame_idx)[7:0], v-ramp =
//  (y+frame_idx)[7:0], checkerboard uses x+frame_idx. Gives scrolling motion.
//  Undefined: frame_idx logic absent, patterns static every frame.
// TESTING (H_ACTIVE=8,H_FP=2,H_SYNC=2,H_BP=2,V_ACTIVE=4,V_FP=1,V_SYNC=1,
//  V_BP=1,CHK_SHIFT=1; H_TOTAL=14, V_TOTAL=7, frame=98 clk)
//  - rst held, en=1 -> outputs at reset values; release -> first de_o 2 clk later.
//  - pat_sel=0, en=1 -> each line data_o 0..7 with de_o, 6 clk de_o=0; 4 lines.
//  - hsync low clk 10-11 of each line; vsync low for line 5 only (POL=0).
//  - pat_sel=2 -> line0 data 00,00,FF,FF,00,00,FF,FF; line2 inverted.
//  - en dropped at pixel (3,1) -> frame completes, busy_o falls after clk 98,
//    no second frame_start_o; pat_sel change mid-frame has no effect.
//  - VGEN_MOVING_EN, pat_sel=0, 3 frames -> line0 starts 00, 01, 02.

Source files
------------

// File: rtl/video_pattern_gen.sv
// -----------------------------------------------------------------------------
// video_pattern_gen
//   Source end of the ISP pixel stream. Produces hsync/vsync/de timing and an
//   8-bit test-pattern pixel per clk so the filter chain can be exercised
//   without a camera. Line order: active, front porch, sync, back porch.
//
//   Optional feature macro: VGEN_MOVING_EN
//     defined   - an 8-bit frame index advances on every frame wrap and is
//                 added to x (and to y for the v-ramp), giving scrolling motion.
//     undefined - no frame index, patterns are identical every frame.
//
// Ports
//   clk            in   pixel clock
//   rst            in   synchronous reset, active-high
//   en             in   run request (level); a started frame always completes
//   pat_sel[1:0]   in   0 h-ramp, 1 v-ramp, 2 checkerboard, 3 constant
//   pat_const[7:0] in   pixel value for the constant pattern
//   hsync_o        out  line sync, active level HS_POL
//   vsync_o        out  frame sync, active level VS_POL
//   de_o           out  active-pixel strobe
//   data_o[7:0]    out  pixel value, 0 outside the active area
//   frame_start_o  out  1-clk pulse coincident with pixel (0,0)
//   busy_o         out  high while a frame is in progress
// -----------------------------------------------------------------------------
module video_pattern_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CHK_SHIFT = 3,
  parameter int CNT_W     = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] pat_sel,
  input  logic [7:0] pat_const,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       de_o,
  output logic [7:0] data_o,
  output logic       frame_start_o,
  output logic       busy_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_last, v_last, frame_last;
  logic             at_origin;

  assign h_last     = (h_cnt == H_LAST);
  assign v_last     = (v_cnt == V_LAST);
  assign frame_last = h_last && v_last;
  assign at_origin  = (state == RUN) && (h_cnt == '0) && (v_cnt == '0);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (frame_last && !en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Raster counters: held at zero in IDLE so RUN always starts at (0,0).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern selection is frozen for the whole frame. At (0,0) the live inputs
  // are used directly so the first pixel already reflects the new choice.
  // ---------------------------------------------------------------------------
  logic [1:0] sel_q;
  logic [7:0] const_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= 2'd0;
      const_q <= 8'd0;
    end else if (at_origin) begin
      sel_q   <= pat_sel;
      const_q <= pat_const;
    end
  end

  logic [7:0] x_eff, y_eff;

`ifdef VGEN_MOVING_EN
  logic [7:0] frame_idx;

  // Advances only when a frame wraps straight into the next one, so the
  // index is held while idle. The new value is in place for pixel (0,0).
  always_ff @(posedge clk) begin
    if (rst)                                   frame_idx <= 8'd0;
    else if (state == RUN && frame_last && en) frame_idx <= frame_idx + 8'd1;
  end

  assign x_eff = h_cnt[7:0] + frame_idx;
  assign y_eff = v_cnt[7:0] + frame_idx;
`else
  assign x_eff = h_cnt[7:0];
  assign y_eff = v_cnt[7:0];
`endif

  logic [1:0] sel;
  logic [7:0] pix;

  always_comb begin
    sel = at_origin ? pat_sel : sel_q;
    pix = 8'd0;
    case (sel)
      2'd0:    pix = x_eff;
      2'd1:    pix = y_eff;
      2'd2:    pix = {8{x_eff[CHK_SHIFT] ^ v_cnt[CHK_SHIFT]}};
      default: pix = at_origin ? pat_const : const_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Timing decode and output registers (one clk after the counters).
  // ---------------------------------------------------------------------------
  logic de_act, hs_act, vs_act;

  assign de_act = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_act = (h_cnt >= HS_START) && (h_cnt < HS_END);
  // v_cnt only changes at h wrap, so vsync edges land at h_cnt == 0.
  assign vs_act = (v_cnt >= VS_START) && (v_cnt < VS_END);

  always_ff @(posedge clk) begin
    if (rst || state != RUN) begin
      hsync_o       <= ~HS_POL;
      vsync_o       <= ~VS_POL;
      de_o          <= 1'b0;
      data_o        <= 8'd0;
      frame_start_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      hsync_o       <= hs_act ? HS_POL : ~HS_POL;
      vsync_o       <= vs_act ? VS_POL : ~VS_POL;
      de_o          <= de_act;
      data_o        <= de_act ? pix : 8'd0;
      frame_start_o <= at_origin;
      busy_o        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_video_pattern_gen
//   Directed bench for video_pattern_gen on a small raster:
//   H 8/2/2/2 (total 14), V 4/1/1/1 (total 7), 98 clk per frame,
//   checkerboard squares of 2 pixels. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_video_pattern_gen;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FRAME = HT * VT;

`ifdef VGEN_MOVING_EN
  localparam bit MOVING = 1'b1;
`else
  localparam bit MOVING = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] pat_sel;
  logic [7:0] pat_const;
  logic       hsync_o, vsync_o, de_o, frame_start_o, busy_o;
  logic [7:0] data_o;

  int checks = 0;
  int errors = 0;
  int fidx   = 0;  // expected frame index in the moving build

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CHK_SHIFT(1), .CNT_W(12)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pat_sel(pat_sel), .pat_const(pat_const),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o), .data_o(data_o),
    .frame_start_o(frame_start_o), .busy_o(busy_o)
  );

  // Expected pixel for an active position.
  function automatic logic [7:0] exp_pix(input int sel, input int x, input int y,
                                         input logic [7:0] c, input int off);
    logic [7:0] xs;
    logic [7:0] ys;
    logic [7:0] yv;
    xs = 8'(x + off);
    ys = 8'(y + off);
    yv = 8'(y);
    case (sel)
      0:       return xs;
      1:       return ys;
      2:       return {8{xs[1] ^ yv[1]}};
      default: return c;
    endcase
  endfunction

  // Checks npix consecutive pixels starting at the current falling edge,
  // which must show pixel (0,0). Optionally changes pat_sel at chg_k and
  // drops en at drop_k (both -1 to disable).
  task automatic walk_frame(input int sel, input logic [7:0] c, input int npix,
                            input int chg_k, input int chg_sel, input int drop_k);
    logic [12:0] exp_v, got_v;
    int x, y, off;
    logic de_e, hs_e, vs_e;
    logic [7:0] d_e;
    off = MOVING ? fidx : 0;
    for (int k = 0; k < npix; k++) begin
      if (k > 0) @(negedge clk);
      x    = k % HT;
      y    = k / HT;
      de_e = (x < 8) && (y < 4);
      hs_e = !(x >= 10 && x < 12);
      vs_e = !(y == 5);
      d_e  = de_e ? exp_pix(sel, x, y, c, off) : 8'd0;
      exp_v = {de_e, hs_e, vs_e, (k == 0), 1'b1, d_e};
      got_v = {de_o, hsync_o, vsync_o, frame_start_o, busy_o, data_o};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL pix(%0d,%0d) {de,hs,vs,fs,busy,data}: got %b_%h, expected %b_%h",
                 x, y, got_v[12:8], got_v[7:0], exp_v[12:8], exp_v[7:0]);
      end
      if (k == chg_k) pat_sel = 2'(chg_sel);
      if (k == drop_k) en = 1'b0;
    end
  endtask

  task automatic check_idle(input string name);
    logic [12:0] got_v;
    got_v = {de_o, hsync_o, vsync_o, frame_start_o, busy_o, data_o};
    checks++;
    if (got_v !== {5'b01100, 8'h00}) begin
      errors++;
      $display("FAIL %s {de,hs,vs,fs,busy,data}: got %b_%h, expected 01100_00",
               name, got_v[12:8], got_v[7:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; pat_sel = 2'd0; pat_const = 8'h00;
    repeat (3) @(negedge clk);
    check_idle("reset_held");
    rst = 1'b0;
    fidx = 0;
    @(negedge clk);
    check_idle("one_clk_after_release");
    @(negedge clk);  // pixel (0,0) must now be on the outputs
  endtask

  // Frame 0 h-ramp (pat_sel changed to 2 mid-frame, ignored), frame 1
  // checkerboard, frame 2 checkerboard with en dropped at (3,1) and a
  // mid-frame switch to constant that must be ignored.
  task automatic test_frames();
    walk_frame(0, 8'h00, FRAME, 20, 2, -1);
    fidx++;
    @(negedge clk);
    walk_frame(2, 8'h00, FRAME, -1, 0, -1);
    pat_sel = 2'd2;
    fidx++;
    @(negedge clk);
    walk_frame(2, 8'h00, FRAME, 40, 3, HT + 3);
  endtask

  task automatic test_en_drop_tail();
    int seen;
    @(negedge clk);
    check_idle("after_last_pixel");
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (frame_start_o || busy_o || de_o) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL idle_after_drop activity cycles: got %0d, expected 0", seen);
    end
  endtask

  task automatic test_const();
    pat_sel = 2'd3; pat_const = 8'hA5; en = 1'b1;
    @(negedge clk);
    check_idle("const_start_latency");
    @(negedge clk);
    walk_frame(3, 8'hA5, FRAME, 30, 0, 50);
    @(negedge clk);
    check_idle("const_end");
  endtask

  task automatic test_rst_mid();
    pat_sel = 2'd1; en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    walk_frame(1, 8'h00, 40, -1, 0, -1);
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst_mid_frame");
    rst = 1'b0; en = 1'b0;
    fidx = 0;
    repeat (4) @(negedge clk);
    check_idle("idle_after_rst");
  endtask

  initial begin
    test_reset();
    test_frames();
    test_en_drop_tail();
    test_const();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
